// File: rtl/decode_pkg.sv
// Shared LC3 decode definitions: opcodes, select encodings and the Execute control word.
package decode_pkg;

    typedef enum logic [3:0] {
        op_br  = 4'b0000,
        op_add = 4'b0001,
        op_ld  = 4'b0010,
        op_st  = 4'b0011,
        op_and = 4'b0101,
        op_ldr = 4'b0110,
        op_str = 4'b0111,
        op_not = 4'b1001,
        op_ldi = 4'b1010,
        op_sti = 4'b1011,
        op_jmp = 4'b1100,
        op_lea = 4'b1110
    } opcode_t;

    typedef enum logic [1:0] {
        alu_add = 2'b00,
        alu_and = 2'b01,
        alu_not = 2'b10
    } alu_t;

    typedef enum logic [1:0] {
        pc1_off11 = 2'b00,
        pc1_off9  = 2'b01,
        pc1_off6  = 2'b10,
        pc1_zero  = 2'b11
    } pcsel1_t;

    typedef enum logic [1:0] {
        w_alu = 2'b00,
        w_mem = 2'b01,
        w_pc  = 2'b10
    } wsel_t;

    typedef struct packed {
        alu_t    alu_control;
        pcsel1_t pcselect1;
        logic    pcselect2;
        logic    op2select;
    } e_control_t;

endpackage

// File: rtl/decode_ctrl_comb.sv
// Combinational opcode decode into Execute, Writeback and Memory control words.
module decode_ctrl_comb
    import decode_pkg::*;
#(
    parameter bit ILLEGAL_ZERO = 1'b1
) (
    input  logic [3:0] opcode,
    input  logic       imm_mode,
    output e_control_t e_control,
    output wsel_t      w_control,
    output logic       mem_control,
    output logic       illegal
);

    opcode_t op;
    assign op = opcode_t'(opcode);

    always_comb begin
        e_control   = '0;
        w_control   = w_alu;
        mem_control = 1'b0;
        illegal     = 1'b0;
        case (op)
            op_add: begin
                e_control.alu_control = alu_add;
                e_control.op2select   = ~imm_mode;
            end
            op_and: begin
                e_control.alu_control = alu_and;
                e_control.op2select   = ~imm_mode;
            end
            op_not: e_control.alu_control = alu_not;
            op_br, op_st: begin
                e_control.pcselect1 = pc1_off9;
                e_control.pcselect2 = 1'b1;
            end
            op_ld: begin
                e_control.pcselect1 = pc1_off9;
                e_control.pcselect2 = 1'b1;
                w_control           = w_mem;
            end
            op_ldi: begin
                e_control.pcselect1 = pc1_off9;
                e_control.pcselect2 = 1'b1;
                w_control           = w_mem;
                mem_control         = 1'b1;
            end
            op_sti: begin
                e_control.pcselect1 = pc1_off9;
                e_control.pcselect2 = 1'b1;
                mem_control         = 1'b1;
            end
            op_lea: begin
                e_control.pcselect1 = pc1_off9;
                e_control.pcselect2 = 1'b1;
                w_control           = w_pc;
            end
            op_ldr: begin
                e_control.pcselect1 = pc1_off6;
                w_control           = w_mem;
            end
            op_str: e_control.pcselect1 = pc1_off6;
            op_jmp: e_control.pcselect1 = pc1_zero;
            default: begin
                // JSR, RTI, reserved, TRAP: either all-zero or treated as a branch.
                illegal = 1'b1;
                if (!ILLEGAL_ZERO) begin
                    e_control.pcselect1 = pc1_off9;
                    e_control.pcselect2 = 1'b1;
                end
            end
        endcase
    end

endmodule

// File: rtl/decode.sv
// LC3 Decode stage: registers IR/npc and the decoded controls on enable_decode.
module decode
    import decode_pkg::*;
#(
    parameter bit ILLEGAL_ZERO = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable_decode,
    input  logic [15:0] dout,
    input  logic [15:0] npc_in,
    output logic [15:0] IR,
    output logic [15:0] npc_out,
    output logic [5:0]  E_Control,
    output logic [1:0]  W_Control,
    output logic        Mem_Control,
    output logic        illegal_op
);

    e_control_t e_next;
    wsel_t      w_next;
    logic       mem_next;
    logic       illegal_next;

    decode_ctrl_comb #(
        .ILLEGAL_ZERO(ILLEGAL_ZERO)
    ) u_ctrl (
        .opcode     (dout[15:12]),
        .imm_mode   (dout[5]),
        .e_control  (e_next),
        .w_control  (w_next),
        .mem_control(mem_next),
        .illegal    (illegal_next)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            IR          <= '0;
            npc_out     <= '0;
            E_Control   <= '0;
            W_Control   <= '0;
            Mem_Control <= 1'b0;
            illegal_op  <= 1'b0;
        end else if (enable_decode) begin
            IR          <= dout;
            npc_out     <= npc_in;
            E_Control   <= e_next;
            W_Control   <= w_next;
            Mem_Control <= mem_next;
            illegal_op  <= illegal_next;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the LC3 decode stage with directed and random instruction streams.
module tb_decode;

    localparam bit IZ = 1'b1;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable_decode = 1'b0;
    logic [15:0] dout = '0;
    logic [15:0] npc_in = '0;
    logic [15:0] IR, npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control, illegal_op;

    decode #(.ILLEGAL_ZERO(IZ)) dut (
        .clock        (clock),
        .reset        (reset),
        .enable_decode(enable_decode),
        .dout         (dout),
        .npc_in       (npc_in),
        .IR           (IR),
        .npc_out      (npc_out),
        .E_Control    (E_Control),
        .W_Control    (W_Control),
        .Mem_Control  (Mem_Control),
        .illegal_op   (illegal_op)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [15:0] ir;
        logic [15:0] npc;
        logic [5:0]  e;
        logic [1:0]  w;
        logic        mem;
        logic        ill;
    } exp_t;

    exp_t q[$];
    exp_t model_state = '0;
    int   errors = 0;
    int   checks = 0;

    // Reference decode written from the instruction-class rules.
    function automatic exp_t ref_decode(input logic [15:0] d, input logic [15:0] n);
        exp_t r;
        int   op;
        int   alu, pc1, pc2, op2, w, mem;
        bit   legal;
        op  = int'(d[15:12]);
        alu = 0; pc1 = 0; pc2 = 0; op2 = 0; w = 0; mem = 0;
        legal = !(op inside {4, 8, 13, 15});
        if (op == 5) alu = 1;
        if (op == 9) alu = 2;
        if ((op == 1 || op == 5) && d[5] == 1'b0) op2 = 1;
        if (op inside {0, 2, 3, 10, 11, 14}) begin pc1 = 1; pc2 = 1; end
        if (op inside {6, 7}) pc1 = 2;
        if (op == 12) pc1 = 3;
        if (op inside {2, 6, 10}) w = 1;
        if (op == 14) w = 2;
        if (op inside {10, 11}) mem = 1;
        if (!legal && !IZ) begin pc1 = 1; pc2 = 1; end
        r.ir  = d;
        r.npc = n;
        r.e   = 6'((alu << 4) + (pc1 << 2) + (pc2 << 1) + op2);
        r.w   = 2'(w);
        r.mem = mem[0];
        r.ill = !legal;
        return r;
    endfunction

    // Drive one cycle; the expected post-edge state comes from the model unless a directed one is supplied.
    task automatic step(input bit rst, input bit en, input logic [15:0] d, input logic [15:0] n,
                        input bit use_dir, input logic [5:0] de, input logic [1:0] dw,
                        input bit dm, input bit di);
        exp_t x;
        @(negedge clock);
        reset = rst; enable_decode = en; dout = d; npc_in = n;
        @(posedge clock);
        if (rst) x = '0;
        else if (en) begin
            x = ref_decode(d, n);
            if (use_dir) begin x.e = de; x.w = dw; x.mem = dm; x.ill = di; end
        end else x = model_state;
        model_state = x;
        q.push_back(x);
    endtask

    task automatic run(input bit rst, input bit en, input logic [15:0] d, input logic [15:0] n);
        step(rst, en, d, n, 1'b0, '0, '0, 1'b0, 1'b0);
    endtask

    task automatic dir(input bit rst, input bit en, input logic [15:0] d, input logic [15:0] n,
                       input logic [5:0] de, input logic [1:0] dw, input bit dm, input bit di);
        step(rst, en, d, n, 1'b1, de, dw, dm, di);
    endtask

    task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Monitor: outputs settle after each edge; compare on the following falling edge.
    always @(negedge clock) begin
        if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            cmp("IR", IR, x.ir);
            cmp("npc_out", npc_out, x.npc);
            cmp("E_Control", 16'(E_Control), 16'(x.e));
            cmp("W_Control", 16'(W_Control), 16'(x.w));
            cmp("Mem_Control", 16'(Mem_Control), 16'(x.mem));
            cmp("illegal_op", 16'(illegal_op), 16'(x.ill));
        end
    end

    initial begin
        // Reset held with enable asserted
        dir(1, 1, 16'h1283, 16'h3000, 6'b000000, 2'd0, 0, 0);
        dir(1, 1, 16'h1283, 16'h3000, 6'b000000, 2'd0, 0, 0);
        dir(0, 1, 16'h1283, 16'h3000, 6'b000001, 2'd0, 0, 0);
        // ALU set
        dir(0, 1, 16'h12A5, 16'h3001, 6'b000000, 2'd0, 0, 0);
        dir(0, 1, 16'h5283, 16'h3002, 6'b010001, 2'd0, 0, 0);
        dir(0, 1, 16'h92BF, 16'h3003, 6'b100000, 2'd0, 0, 0);
        // Memory / PC-relative
        dir(0, 1, 16'hA205, 16'h3004, 6'b000110, 2'd1, 1, 0);
        dir(0, 1, 16'h6281, 16'h3005, 6'b001000, 2'd1, 0, 0);
        dir(0, 1, 16'hE205, 16'h3006, 6'b000110, 2'd2, 0, 0);
        dir(0, 1, 16'hC080, 16'h3007, 6'b001100, 2'd0, 0, 0);
        // Stall
        dir(0, 1, 16'h0E05, 16'h3008, 6'b000110, 2'd0, 0, 0);
        for (int i = 0; i < 3; i++) run(0, 0, 16'h1283, 16'h4000 + 16'(i));
        dir(0, 1, 16'h1283, 16'h3009, 6'b000001, 2'd0, 0, 0);
        // Illegal then legal
        dir(0, 1, 16'hF025, 16'h300A, 6'b000000, 2'd0, 0, 1);
        dir(0, 1, 16'h5283, 16'h300B, 6'b010001, 2'd0, 0, 0);
        // Reset coincident with an LDI
        dir(1, 1, 16'hA205, 16'h300C, 6'b000000, 2'd0, 0, 0);
        dir(0, 1, 16'hA205, 16'h300D, 6'b000110, 2'd1, 1, 0);
        // Every opcode once, then random traffic
        for (int op = 0; op < 16; op++)
            run(0, 1, {4'(op), 12'($urandom)}, 16'($urandom));
        for (int i = 0; i < 300; i++)
            run($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
                16'($urandom), 16'($urandom));
        begin
            int budget = 10;
            while (q.size() > 0 && budget > 0) begin
                @(posedge clock);
                budget--;
            end
            if (q.size() > 0) begin
                errors++;
                checks++;
                $display("FAIL drain actual=%0d pending required=0", q.size());
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
